// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - CPU request/response and data-memory port bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_BITS = 10
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_op;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [31:0]          req_pc;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [ADDR_BITS-1:0] mem_a;
    logic [31:0]          mem_wd;
    logic [31:0]          mem_pc;
    logic [31:0]          mem_rd;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_we, mem_addr, mem_a, mem_wd, mem_pc
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_we, mem_addr, mem_a, mem_wd, mem_pc
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: alignment check, lane select/extend, read-modify-write sub-word stores
module mem_access_unit #(
    parameter int ADDR_BITS = 10
) (
    input  logic            clk,
    input  logic            reset,
    mem_access_unit_if.slave bus
);
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic        mem_we_q;
    logic [31:0] mem_wd_q;

    logic        misaligned_d;
    logic [31:0] byte_shift_d;
    logic [31:0] half_shift_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    always_comb begin
        misaligned_d = 1'b0;
        case (bus.req_op)
            OP_LW, OP_SW:         misaligned_d = |bus.req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: misaligned_d = bus.req_addr[0];
            default:              misaligned_d = 1'b0;
        endcase
    end

    // Lane extraction and sub-word merge both work on the word currently addressed by mem_a.
    always_comb begin
        byte_shift_d = bus.mem_rd >> {addr_q[1:0], 3'b000};
        half_shift_d = bus.mem_rd >> {addr_q[1], 4'b0000};
        load_d       = 32'd0;
        case (op_q)
            OP_LW:   load_d = bus.mem_rd;
            OP_LH:   load_d = {{16{half_shift_d[15]}}, half_shift_d[15:0]};
            OP_LHU:  load_d = {16'd0, half_shift_d[15:0]};
            OP_LB:   load_d = {{24{byte_shift_d[7]}}, byte_shift_d[7:0]};
            OP_LBU:  load_d = {24'd0, byte_shift_d[7:0]};
            default: load_d = 32'd0;
        endcase
        merge_d = bus.mem_rd;
        if (op_q == OP_SB) begin
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (op_q == OP_SH) begin
            merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LW;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            pc_q        <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_wd_q    <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wd_q    <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= bus.req_op;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        pc_q        <= bus.req_pc;
                        req_ready_q <= 1'b0;
                        if (misaligned_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else begin
                            state_q <= S_ACCESS;
                            if (bus.req_op == OP_SW) begin
                                mem_we_q <= 1'b1;
                                mem_wd_q <= bus.req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (op_q == OP_SH || op_q == OP_SB) begin
                        state_q  <= S_WRITE;
                        mem_we_q <= 1'b1;
                        mem_wd_q <= merge_d;
                    end else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_d;
                    end
                end
                S_WRITE: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wd    = mem_wd_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_a     = addr_q[ADDR_BITS+1:2];
    assign bus.mem_pc    = pc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit against a byte-array model
module tb_mem_access_unit;
    localparam int AB = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_BITS(AB)) mif ();

    mem_access_unit #(.ADDR_BITS(AB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    logic [31:0] mem [0:(1<<AB)-1];
    logic        bd_we = 1'b0;
    logic [AB-1:0] bd_idx = '0;
    logic [31:0] bd_val = 32'd0;

    assign mif.mem_rd = mem[mif.mem_a];

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        else if (mif.mem_we) mem[mif.mem_a] <= mif.mem_wd;
    end

    logic [7:0] ref_b [0:63];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        bd_we = 1'b1; bd_idx = AB'(idx); bd_val = val;
        @(negedge clk);
        bd_we = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[idx*4+k] = val[8*k +: 8];
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd5: return 4;
            3'd1, 3'd2, 3'd6: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int base);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_b[base + k];
        return w;
    endfunction

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, output logic [31:0] o_rdata,
                          output logic [31:0] o_wd, output int o_lat);
        int sz, base, exp_lat, we_cyc, n;
        bit is_store, mis, sgn;
        logic [31:0] exp_rd, exp_wd, v;
        sz = op_size(op);
        is_store = (op >= 3'd5);
        mis = (int'(addr[1:0]) % sz) != 0;
        sgn = (op == 3'd1 || op == 3'd3);
        base = int'(addr[5:0]);
        exp_rd = 32'd0; exp_wd = 32'd0; we_cyc = 0;
        if (mis) exp_lat = 1;
        else if (op == 3'd6 || op == 3'd7) exp_lat = 3;
        else exp_lat = 2;
        if (!mis && !is_store) begin
            v = 32'd0;
            for (int j = 0; j < sz; j++) v = v | (32'(ref_b[base + j]) << (8*j));
            if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            exp_rd = v;
        end
        if (!mis && is_store) begin
            for (int j = 0; j < sz; j++) ref_b[base + j] = wdata[8*j +: 8];
            exp_wd = (op == 3'd5) ? wdata : ref_word(base & ~3);
            we_cyc = (op == 3'd5) ? 1 : 2;
        end
        n = 0;
        while (mif.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", 32'(n < 20), 32'd1);
        mif.req_valid = 1'b1; mif.req_op = op; mif.req_addr = addr;
        mif.req_wdata = wdata; mif.req_pc = pc;
        @(negedge clk);
        mif.req_valid = 1'b0; mif.req_op = 3'($urandom); mif.req_addr = $urandom;
        mif.req_wdata = $urandom; mif.req_pc = $urandom;
        o_lat = 1; o_wd = 32'd0;
        forever begin
            chk("mem_we", 32'(mif.mem_we), 32'(o_lat == we_cyc));
            if (mif.mem_we === 1'b1) begin
                o_wd = mif.mem_wd;
                chk("mem_wd", mif.mem_wd, exp_wd);
                chk("mem_a", 32'(mif.mem_a), 32'(addr[AB+1:2]));
            end else begin
                chk("mem_wd_idle", mif.mem_wd, 32'd0);
            end
            if (o_lat == 1) begin
                chk("mem_pc", mif.mem_pc, pc);
                chk("mem_addr", mif.mem_addr, addr & 32'hFFFF_FFFC);
                chk("busy_ready", 32'(mif.req_ready), 32'd0);
            end
            if (mif.rsp_valid === 1'b1 || o_lat >= 8) break;
            o_lat++;
            @(negedge clk);
        end
        o_rdata = mif.rsp_rdata;
        chk("latency", 32'(o_lat), 32'(exp_lat));
        chk("rsp_rdata", mif.rsp_rdata, exp_rd);
        chk("rsp_err", 32'(mif.rsp_err), 32'(mis));
        @(negedge clk);
        chk("rsp_pulse", 32'(mif.rsp_valid), 32'd0);
        chk("rsp_hold", mif.rsp_rdata, exp_rd);
        chk("idle_ready", 32'(mif.req_ready), 32'd1);
    endtask

    logic [31:0] rd, wd;
    int lat;
    logic [2:0] rop;
    logic [31:0] raddr;

    initial begin
        mif.req_valid = 1'b0; mif.req_op = 3'd0; mif.req_addr = 32'd0;
        mif.req_wdata = 32'd0; mif.req_pc = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(mif.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(mif.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(mif.rsp_err), 32'd0);
        chk("rst_rsp_rdata", mif.rsp_rdata, 32'd0);
        chk("rst_mem_we", 32'(mif.mem_we), 32'd0);
        chk("rst_mem_wd", mif.mem_wd, 32'd0);
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_mem_a", 32'(mif.mem_a), 32'd0);
        chk("rst_mem_pc", mif.mem_pc, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) set_word(i, $urandom);

        do_req(3'd5, 32'h10, 32'h1234_5678, 32'h100, rd, wd, lat);
        chk("d_sw_wd", wd, 32'h1234_5678);
        chk("d_sw_lat", 32'(lat), 32'd2);

        set_word(4, 32'h80FF_7F01);
        do_req(3'd3, 32'h13, 32'd0, 32'h104, rd, wd, lat); chk("d_lb13", rd, 32'hFFFF_FF80);
        do_req(3'd4, 32'h13, 32'd0, 32'h108, rd, wd, lat); chk("d_lbu13", rd, 32'h0000_0080);
        do_req(3'd3, 32'h11, 32'd0, 32'h10C, rd, wd, lat); chk("d_lb11", rd, 32'h0000_007F);
        do_req(3'd1, 32'h12, 32'd0, 32'h110, rd, wd, lat); chk("d_lh12", rd, 32'hFFFF_80FF);
        do_req(3'd2, 32'h12, 32'd0, 32'h114, rd, wd, lat); chk("d_lhu12", rd, 32'h0000_80FF);
        do_req(3'd0, 32'h10, 32'd0, 32'h118, rd, wd, lat); chk("d_lw10", rd, 32'h80FF_7F01);

        set_word(4, 32'h1234_5678);
        do_req(3'd7, 32'h11, 32'h0000_00AB, 32'h11C, rd, wd, lat);
        chk("d_sb_wd", wd, 32'h1234_AB78); chk("d_sb_lat", 32'(lat), 32'd3);
        set_word(4, 32'h1234_5678);
        do_req(3'd6, 32'h12, 32'h0000_BEEF, 32'h120, rd, wd, lat);
        chk("d_sh_wd", wd, 32'hBEEF_5678); chk("d_sh_lat", 32'(lat), 32'd3);

        do_req(3'd0, 32'h02, 32'd0, 32'h124, rd, wd, lat);
        chk("d_lw_mis_lat", 32'(lat), 32'd1); chk("d_lw_mis_rd", rd, 32'd0);
        do_req(3'd6, 32'h13, 32'h5555, 32'h128, rd, wd, lat);
        chk("d_sh_mis_lat", 32'(lat), 32'd1); chk("d_sh_mis_wd", wd, 32'd0);

        // Reset lands on the edge closing WRITE; that cycle's write still reaches memory.
        mif.req_valid = 1'b1; mif.req_op = 3'd7; mif.req_addr = 32'h11;
        mif.req_wdata = 32'h0000_00CD; mif.req_pc = 32'h12C;
        @(negedge clk);
        mif.req_valid = 1'b0;
        @(negedge clk);
        chk("r_write_we", 32'(mif.mem_we), 32'd1);
        ref_b[17] = 8'hCD;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("r_we", 32'(mif.mem_we), 32'd0);
        chk("r_ready", 32'(mif.req_ready), 32'd1);
        chk("r_rsp_valid", 32'(mif.rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("r_no_rsp", 32'(mif.rsp_valid), 32'd0);
        end
        do_req(3'd0, 32'h10, 32'd0, 32'h130, rd, wd, lat);
        chk("r_lw_lat", 32'(lat), 32'd2);

        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom);
            raddr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            do_req(rop, raddr, $urandom, $urandom, rd, wd, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
